// File: rtl/instr_encoder.sv
// MIPS instruction encoder: packs accepted descriptors into 32-bit words and
// streams them into consecutive instruction-memory addresses from a loadable base.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              running,
    output logic              full,
    output logic              err
);

    localparam logic [3:0] KIND_NOP = 4'd0;
    localparam logic [3:0] KIND_ADD = 4'd1;
    localparam logic [3:0] KIND_SUB = 4'd2;
    localparam logic [3:0] KIND_ORI = 4'd3;
    localparam logic [3:0] KIND_LUI = 4'd4;
    localparam logic [3:0] KIND_LW  = 4'd5;
    localparam logic [3:0] KIND_SW  = 4'd6;
    localparam logic [3:0] KIND_BEQ = 4'd7;
    localparam logic [3:0] KIND_J   = 4'd8;

    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    // Fields not used by a format are left at zero so the word is canonical.
    function automatic logic [31:0] encode_word(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] word;
        case (kind)
            KIND_NOP: word = 32'h0000_0000;
            KIND_ADD: word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            KIND_SUB: word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
            KIND_ORI: word = {6'h0D, rs, rt, imm};
            KIND_LUI: word = {6'h0F, 5'd0, rt, imm};
            KIND_LW:  word = {6'h23, rs, rt, imm};
            KIND_SW:  word = {6'h2B, rs, rt, imm};
            KIND_BEQ: word = {6'h04, rs, rt, imm};
            KIND_J:   word = {6'h02, target};
            default:  word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    state_t              state_r;
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic                imem_we_r;
    logic [ADDR_W-1:0]   imem_addr_r;
    logic [31:0]         imem_wdata_r;
    logic [ADDR_W:0]     count_r;
    logic                running_r;
    logic                full_r;
    logic                err_r;

    logic                in_ready_s;
    logic                accept_s;
    logic                legal_s;
    logic [31:0]         word_s;

    // Acceptance window: only in RUN, and never in a cycle carrying start or stop.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_RUN:  in_ready_s = !start && !stop;
            ST_IDLE: in_ready_s = 1'b0;
            ST_FULL: in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    assign accept_s = in_valid && in_ready_s;
    assign legal_s  = (in_kind <= KIND_J);
    assign word_s   = encode_word(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);

    // Control FSM plus the registered write port; start takes precedence over stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {ADDR_W{1'b0}};
            imem_we_r    <= 1'b0;
            imem_addr_r  <= {ADDR_W{1'b0}};
            imem_wdata_r <= 32'h0000_0000;
            count_r      <= {(ADDR_W + 1){1'b0}};
            running_r    <= 1'b0;
            full_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            imem_we_r <= 1'b0;
            if (start) begin
                state_r   <= ST_RUN;
                running_r <= 1'b1;
                full_r    <= 1'b0;
                wr_ptr_r  <= base_addr;
                count_r   <= {(ADDR_W + 1){1'b0}};
                err_r     <= 1'b0;
            end else if (stop) begin
                state_r   <= ST_IDLE;
                running_r <= 1'b0;
                full_r    <= 1'b0;
            end else if (accept_s) begin
                if (legal_s) begin
                    imem_we_r    <= 1'b1;
                    imem_addr_r  <= wr_ptr_r;
                    imem_wdata_r <= word_s;
                    wr_ptr_r     <= wr_ptr_r + PTR_ONE;
                    count_r      <= count_r + CNT_ONE;
                    // The top address is still written; after it the block stalls.
                    if (wr_ptr_r == PTR_MAX) begin
                        state_r   <= ST_FULL;
                        running_r <= 1'b0;
                        full_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_RUN;
                    end
                end else begin
                    err_r <= 1'b1;
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign count      = count_r;
    assign running    = running_r;
    assign full       = full_r;
    assign err        = err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the encoder.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, in_valid;
    logic [7:0]  base_addr;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  count;
    logic        running, full, err;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: mode 0 idle, 1 run, 2 full
    int          m_mode, m_ptr, m_cnt;
    bit          m_err, m_we;
    int          m_addr;
    logic [31:0] m_data;

    instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .running(running), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned itype(longint unsigned op, longint unsigned rs,
                                              longint unsigned rt, longint unsigned imm);
        return op * 67108864 + rs * 2097152 + rt * 65536 + imm;
    endfunction

    function automatic logic [31:0] ref_word(int kind, int rs, int rt, int rd, int imm, int tgt);
        longint unsigned w;
        case (kind)
            1: w = rs * 2097152 + rt * 65536 + rd * 2048 + 32;
            2: w = rs * 2097152 + rt * 65536 + rd * 2048 + 34;
            3: w = itype(13, rs, rt, imm);
            4: w = itype(15, 0, rt, imm);
            5: w = itype(35, rs, rt, imm);
            6: w = itype(43, rs, rt, imm);
            7: w = itype(4, rs, rt, imm);
            8: w = 2 * 67108864 + tgt;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
        m_we = 0; m_addr = 0; m_data = 32'h0;
    endfunction

    function automatic bit model_ready();
        return (m_mode == 1) && !start && !stop;
    endfunction

    function automatic void model_edge();
        bit acc;
        acc  = model_ready() && in_valid;
        m_we = 0;
        if (start) begin
            m_mode = 1; m_ptr = base_addr; m_cnt = 0; m_err = 0;
        end else if (stop) begin
            m_mode = 0;
        end
        if (acc) begin
            if (in_kind <= 8) begin
                m_we   = 1;
                m_addr = m_ptr;
                m_data = ref_word(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);
                if (m_ptr == 255) m_mode = 2;
                m_ptr  = (m_ptr + 1) % 256;
                m_cnt++;
            end else begin
                m_err = 1;
            end
        end
    endfunction

    task automatic check_outputs();
        check_eq("imem_we", imem_we, m_we);
        if (m_we) begin
            check_eq("imem_addr", imem_addr, m_addr);
            check_eq("imem_wdata", imem_wdata, m_data);
        end
        check_eq("count", count, m_cnt);
        check_eq("err", err, m_err);
        check_eq("running", running, m_mode == 1);
        check_eq("full", full, m_mode == 2);
    endtask

    // One clock: drive inputs, check in_ready, step model at the edge, check outputs.
    task automatic step(input logic st, input logic sp, input logic v, input logic [3:0] k,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [15:0] imm, input logic [25:0] tg, input logic [7:0] base);
        start = st; stop = sp; in_valid = v; in_kind = k;
        in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tg; base_addr = base;
        #1;
        check_eq("in_ready", in_ready, model_ready());
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_start(input logic [7:0] base);
        step(1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, base);
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 8'h00);
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg);
        step(1'b0, 1'b0, 1'b1, k, rs, rt, rd, imm, tg, 8'h00);
    endtask

    task automatic expect_write(input string tag, input logic [7:0] a, input logic [31:0] d);
        check_eq({tag, "_we"}, imem_we, 1'b1);
        check_eq({tag, "_addr"}, imem_addr, a);
        check_eq({tag, "_data"}, imem_wdata, d);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_kind = 4'd0;
        in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'h0; in_target = 26'h0;
        base_addr = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_addr", imem_addr, 8'h00);
        check_eq("rst_wdata", imem_wdata, 32'h0);
        check_outputs();
        rst_n = 1'b1;

        // ADD then SUB from base 0x10
        do_start(8'h10);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        expect_write("add", 8'h10, 32'h00221820);
        send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        expect_write("sub", 8'h11, 32'h00221822);
        check_eq("count2", count, 9'd2);
        idle_cycle();

        // back-to-back I/J-type encodings
        send(4'd3, 5'd0, 5'd8, 5'd0, 16'h00FF, 26'h0);
        expect_write("ori", 8'h12, 32'h340800FF);
        send(4'd4, 5'd7, 5'd8, 5'd5, 16'h1234, 26'h0);
        expect_write("lui", 8'h13, 32'h3C081234);
        send(4'd5, 5'd29, 5'd9, 5'd0, 16'h0004, 26'h0);
        expect_write("lw", 8'h14, 32'h8FA90004);
        send(4'd6, 5'd29, 5'd9, 5'd0, 16'h0004, 26'h0);
        expect_write("sw", 8'h15, 32'hAFA90004);
        send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        expect_write("beq", 8'h16, 32'h1022FFFF);
        send(4'd8, 5'd3, 5'd4, 5'd5, 16'h1111, 26'h10);
        expect_write("j", 8'h17, 32'h08000010);

        // illegal kind between two ADDs
        do_start(8'h40);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        send(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        check_eq("illegal_err", err, 1'b1);
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        expect_write("add_after_ill", 8'h41, 32'h00853020);
        check_eq("ill_count", count, 9'd2);
        idle_cycle();
        check_eq("err_sticky", err, 1'b1);
        do_start(8'h00);
        check_eq("err_cleared", err, 1'b0);

        // fill to the top of memory
        do_start(8'hFE);
        send(4'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        send(4'd1, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0);
        expect_write("top", 8'hFF, 32'h00421020);
        check_eq("full_set", full, 1'b1);
        send(4'd1, 5'd3, 5'd3, 5'd3, 16'h0, 26'h0);
        check_eq("full_held_we", imem_we, 1'b0);
        check_eq("full_count", count, 9'd2);
        step(1'b0, 1'b1, 1'b1, 4'd1, 5'd3, 5'd3, 5'd3, 16'h0, 26'h0, 8'h00);
        check_eq("stop_full", full, 1'b0);

        // start+stop together, then stop right after an accept
        do_start(8'h20);
        step(1'b1, 1'b1, 1'b1, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 8'h30);
        check_eq("ss_running", running, 1'b1);
        check_eq("ss_no_write", imem_we, 1'b0);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        expect_write("after_ss", 8'h30, 32'h00221820);
        send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        step(1'b0, 1'b1, 1'b1, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 8'h00);
        check_eq("stop_running", running, 1'b0);
        check_eq("stop_count", count, 9'd2);

        // reset right after an accept discards the pending write
        do_start(8'h50);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("mid_rst_we", imem_we, 1'b0);
        check_eq("mid_rst_addr", imem_addr, 8'h00);
        check_eq("mid_rst_wdata", imem_wdata, 32'h0);
        check_eq("mid_rst_ready", in_ready, 1'b0);
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic st, sp, v;
            logic [3:0] k;
            logic [7:0] b;
            st = ($urandom_range(0, 99) < 3);
            sp = ($urandom_range(0, 99) < 2);
            v  = ($urandom_range(0, 99) < 75);
            k  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
            b  = ($urandom_range(0, 2) == 0) ? 8'(8'hF0 + $urandom_range(0, 15)) : 8'($urandom);
            step(st, sp, v, k, 5'($urandom), 5'($urandom), 5'($urandom),
                 16'($urandom), 26'($urandom), b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and instruction-memory writer; the inverse of the control/decode path. It accepts instruction descriptors (kind plus register, immediate and target fields) over a valid/ready handshake and packs each one into a 32-bit MIPS word. It writes the words to consecutive instruction-memory addresses starting at a programmable base. The block sits between the test/boot loader and the instruction memory's write port.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: load base, clear count/err, enter RUN
- stop  in  1  pulse: return to IDLE
- base_addr  in  ADDR_W  first write address, sampled on start
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- in_kind  in  4  0 NOP, 1 ADD, 2 SUB, 3 ORI, 4 LUI, 5 LW, 6 SW, 7 BEQ, 8 J, 9–15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / branch offset
- in_target  in  26  jump target
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since start
- running  out  1  state == RUN
- full  out  1  state == FULL
- err  out  1  sticky: illegal kind received since start

## Operation
- States: IDLE, RUN, FULL. Reset state is IDLE.
- IDLE:
  - start → RUN, wr_ptr = base_addr, count = 0, err = 0.
- RUN:
  - in_ready = 1 unless start or stop is asserted this cycle.
  - stop → IDLE.
  - start → re-init, exactly as from IDLE.
- FULL:
  - in_ready = 0.
  - start → re-init into RUN.
  - stop → IDLE.
- Priority: start beats stop. Either one blocks acceptance that cycle.
- On an accepted legal kind:
  - Encoded word is registered.
  - Next cycle: imem_we = 1, imem_addr = wr_ptr at accept time.
  - wr_ptr += 1 (wraps modulo 2^ADDR_W); count += 1.
- Accept at wr_ptr == 2^ADDR_W−1 → FULL next cycle. That final word is still written.
- Illegal kind (9–15):
  - Descriptor is consumed.
  - No write, no pointer/count change.
  - err = 1 until the next start or reset.
- Encoding, fields MSB→LSB (opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6]=0, funct[5:0]):
  - NOP: 0x00000000
  - ADD: op 0x00, funct 0x20, rs/rt/rd
  - SUB: op 0x00, funct 0x22, rs/rt/rd
  - ORI: op 0x0D, rs, rt, imm
  - LUI: op 0x0F, rs forced 0, rt, imm
  - LW: op 0x23, rs, rt, imm
  - SW: op 0x2B, rs, rt, imm
  - BEQ: op 0x04, rs, rt, imm
  - J: op 0x02, target[25:0]
  - Unused fields are forced to 0 (e.g. in_rd is ignored for I-type).

## Timing
- Reset values: imem_we = 0, imem_addr = 0, imem_wdata = 0, count = 0, err = 0, running = 0, full = 0, in_ready = 0, wr_ptr = 0.
- Latency: accept edge → imem_we high for exactly one cycle after it; addr and wdata are valid in that same cycle.
- Throughput: one word per cycle with back-to-back accepts.
- in_ready is combinational from state, start and stop only (no dependence on in_valid).
- A write already registered when stop/start arrives still completes in the following cycle.
- count updates in the same cycle the corresponding imem_we is high.
- Reset asserted mid-run clears everything immediately. A pending write is discarded (imem_we = 0 during and after reset).

## Test plan
- Reset, then start with base_addr = 0x10:
  - ADD rs1 rt2 rd3 → imem_we 1 cycle later, addr 0x10, data 0x00221820.
  - Then SUB, same registers → addr 0x11, data 0x00221822.
  - count = 2.
- Back-to-back encodings, one per cycle:
  - ORI rt8 imm 0x00FF → 0x340800FF
  - LUI rt8 imm 0x1234 → 0x3C081234
  - LW rs29 rt9 imm 4 → 0x8FA90004
  - SW rs29 rt9 imm 4 → 0xAFA90004
  - BEQ rs1 rt2 imm 0xFFFF → 0x1022FFFF
  - J target 0x10 → 0x08000010
  - Writes land on consecutive addresses with no bubbles.
- Illegal kind 12 between two ADDs:
  - err goes 1 and stays.
  - The two ADDs land on adjacent addresses; count = 2.
  - A new start clears err.
- start with base_addr = 0xFE:
  - Three valid descriptors offered; the first two are written at 0xFE and 0xFF.
  - full = 1, in_ready = 0; the third is held, not accepted.
  - stop → IDLE, full = 0.
- Simultaneous events:
  - start and stop together in RUN → re-init to RUN with no accept that cycle.
  - stop the cycle after an accept → that write still occurs.
- Assert rst_n low the cycle after an accept → no imem_we pulse, all outputs at reset values.
